// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// States, ACK/NACK levels and byte width.
package i2c_pkg;

  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA synchroniser, glitch filter and bus event detect.
// Ports: clk, PRESET, scl_i, sda_i -> sda_f, scl_rise, scl_fall, start, stop.
module i2c_line_filter #(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic PRESET,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam int CW =
    (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(FILTER_LEN - 1);

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    filt;
  logic [1:0]    filt_q;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (PRESET) begin
      s1     <= '1;
      s2     <= '1;
      filt   <= '1;
      filt_q <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1     <= {sda_i, scl_i};
      s2     <= s1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] & filt_q[0];
  assign start    = filt[0] & filt_q[0] &
                    filt_q[1] & ~filt[1];
  assign stop     = filt[0] & filt_q[0] &
                    ~filt_q[1] & filt[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with pointer-addressed register file.
// Ports: clk, PRESET, scl_i, sda_i, sda_oe, busy, wr_*, host_ptr/host_rdata.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int NUM_REGS   = 16,
  localparam int PTR_W     = $clog2(NUM_REGS),
  parameter int FILTER_LEN = 2,
  parameter int AUTO_INC   = 1
) (
  input  logic             clk,
  input  logic             PRESET,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] host_ptr,
  output logic [7:0]       host_rdata
);

  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk      (clk),
    .PRESET   (PRESET),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_f    (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_tgt_state_e        st;
  logic [I2C_BYTE_W-1:0] sr;
  logic [2:0]            bitcnt;
  logic                  phase;
  logic                  ack_ok;
  logic                  rw;
  logic [PTR_W-1:0]      ptr;
  logic [7:0]            regs [NUM_REGS];

  logic [7:0]       rx_byte;
  logic             rx_ok;
  logic [PTR_W-1:0] ptr_nx;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    logic [PTR_W-1:0] r;
    r = p + 1'b1;
    if (32'(p) == NUM_REGS - 1) r = '0;
    return r;
  endfunction

  assign rx_byte = {sr[6:0], sda_f};
  assign rx_ok   = 32'(rx_byte) < NUM_REGS;
  assign ptr_nx  = (AUTO_INC != 0) ? inc(ptr) : ptr;

  assign host_rdata =
    (32'(host_ptr) < NUM_REGS) ? regs[host_ptr] : '0;

  always_ff @(posedge clk) begin
    if (PRESET) begin
      st       <= IDLE;
      sr       <= '0;
      bitcnt   <= 3'd7;
      phase    <= 1'b0;
      ack_ok   <= 1'b0;
      rw       <= 1'b0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_ptr   <= '0;
      wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (stop) begin
        st     <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        phase  <= 1'b0;
      end else if (start) begin
        st     <= ADDR;
        bitcnt <= 3'd7;
        sda_oe <= 1'b0;
        phase  <= 1'b0;
      end else begin
        unique case (st)
          IDLE: ;
          ADDR: if (scl_rise) begin
            sr     <= rx_byte;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                st     <= ADDR_ACK;
                rw     <= rx_byte[0];
                busy   <= 1'b1;
                ack_ok <= 1'b1;
              end else begin
                st <= IDLE;
              end
            end
          end
          PTR: if (scl_rise) begin
            sr     <= rx_byte;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              st     <= PTR_ACK;
              ack_ok <= rx_ok;
              if (rx_ok) ptr <= rx_byte[PTR_W-1:0];
            end
          end
          WDATA: if (scl_rise) begin
            sr     <= rx_byte;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              st        <= WDATA_ACK;
              ack_ok    <= 1'b1;
              regs[ptr] <= rx_byte;
              wr_valid  <= 1'b1;
              wr_ptr    <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr_nx;
            end
          end
          // first fall drives ACK/NACK, second ends it
          ADDR_ACK, PTR_ACK, WDATA_ACK:
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= ack_ok;
                phase  <= 1'b1;
              end else begin
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                bitcnt <= 3'd7;
                unique case (st)
                  ADDR_ACK:
                    if (rw) begin
                      st     <= RDATA;
                      sr     <= regs[ptr];
                      sda_oe <= ~regs[ptr][7];
                    end else begin
                      st <= PTR;
                    end
                  PTR_ACK:
                    st <= ack_ok ? WDATA : IDLE;
                  default:
                    st <= WDATA;
                endcase
              end
            end
          RDATA: if (scl_fall) begin
            if (bitcnt == 3'd0) begin
              st     <= RACK;
              sda_oe <= 1'b0;
              phase  <= 1'b0;
            end else begin
              sda_oe <= ~sr[6];
              sr     <= {sr[6:0], 1'b0};
              bitcnt <= bitcnt - 3'd1;
            end
          end
          RACK: begin
            if (scl_rise && !phase) begin
              ptr <= ptr_nx;
              if (sda_f == I2C_ACK) phase <= 1'b1;
              else                  st    <= IDLE;
            end else if (scl_fall && phase) begin
              phase  <= 1'b0;
              st     <= RDATA;
              bitcnt <= 3'd7;
              sr     <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboarded bench for i2c_target_regfile.
// Bit-banged open-drain master on a 10 ns clock.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       PRESET = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       busy;
  logic       wr_valid;
  logic [3:0] wr_ptr;
  logic [7:0] wr_data;
  logic [3:0] host_ptr = '0;
  logic [7:0] host_rdata;

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_q [$];
  logic [7:0]  rd_q [$];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_regfile dut (
    .clk        (clk),
    .PRESET     (PRESET),
    .scl_i      (m_scl),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_valid   (wr_valid),
    .wr_ptr     (wr_ptr),
    .wr_data    (wr_data),
    .host_ptr   (host_ptr),
    .host_rdata (host_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!PRESET && wr_valid) begin
      chk("wr_pend", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0)
        chk("wr", {wr_ptr, wr_data},
            wr_q.pop_front());
    end
  end

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_c();
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b1; wt(2 * Q);
  endtask

  task automatic bit_c(
    input  logic b,
    output logic r
  );
    m_sda = b; wt(Q);
    m_scl = 1'b1; wt(Q);
    @(negedge clk) r = sda_bus;
    wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic byte_w(
    input  logic [7:0] b,
    output logic       ack
  );
    logic r;
    for (int i = 7; i >= 0; i--)
      bit_c(b[i], r);
    bit_c(1'b1, ack);
  endtask

  task automatic wr_ack(
    input string      tag,
    input logic [7:0] b,
    input logic       exp
  );
    logic a;
    byte_w(b, a);
    chk(tag, 32'(a), 32'(exp));
  endtask

  task automatic rd_byte(
    input string tag,
    input logic  mack
  );
    logic [7:0] d;
    logic       r;
    for (int i = 7; i >= 0; i--) begin
      bit_c(1'b1, r);
      d[i] = r;
    end
    bit_c(mack, r);
    chk(tag, 32'(d), 32'(rd_q.pop_front()));
  endtask

  task automatic peek(
    input string      tag,
    input logic [3:0] p,
    input logic [7:0] exp
  );
    host_ptr = p;
    @(negedge clk);
    chk(tag, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic r;
    wt(5);
    @(negedge clk);
    chk("rst_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wv", 32'(wr_valid), 0);
    chk("rst_wp", 32'(wr_ptr), 0);
    chk("rst_wd", 32'(wr_data), 0);
    PRESET = 1'b0;
    wt(10);
    for (int i = 0; i < 16; i++)
      peek("rst_reg", 4'(i), 8'h00);

    // write burst
    wr_q.push_back({4'd2, 8'hA5});
    wr_q.push_back({4'd3, 8'h5A});
    start_c();
    wr_ack("w_addr", 8'h78, I2C_ACK);
    chk("w_busy", 32'(busy), 1);
    wr_ack("w_ptr", 8'h02, I2C_ACK);
    wr_ack("w_d0", 8'hA5, I2C_ACK);
    wr_ack("w_d1", 8'h5A, I2C_ACK);
    stop_c();
    chk("w_busy_p", 32'(busy), 0);
    peek("w_reg2", 4'd2, 8'hA5);
    peek("w_reg3", 4'd3, 8'h5A);

    // random read through repeated START
    start_c();
    wr_ack("r_addr", 8'h78, I2C_ACK);
    wr_ack("r_ptr", 8'h02, I2C_ACK);
    start_c();
    wr_ack("r_addr2", 8'h79, I2C_ACK);
    rd_q.push_back(8'hA5);
    rd_q.push_back(8'h5A);
    rd_byte("r_d0", I2C_ACK);
    rd_byte("r_d1", I2C_NACK);
    chk("r_busy", 32'(busy), 1);
    stop_c();
    chk("r_busy_p", 32'(busy), 0);

    // pointer wrap
    wr_q.push_back({4'd15, 8'h11});
    wr_q.push_back({4'd0, 8'h22});
    start_c();
    wr_ack("wr_addr", 8'h78, I2C_ACK);
    wr_ack("wr_ptr", 8'h0F, I2C_ACK);
    wr_ack("wr_d0", 8'h11, I2C_ACK);
    wr_ack("wr_d1", 8'h22, I2C_ACK);
    stop_c();
    peek("wr_reg15", 4'd15, 8'h11);
    peek("wr_reg0", 4'd0, 8'h22);

    // address mismatch
    start_c();
    wr_ack("mm_addr", 8'h7A, I2C_NACK);
    chk("mm_busy", 32'(busy), 0);
    stop_c();

    // invalid pointer keeps old pointer
    start_c();
    wr_ack("ip_addr", 8'h78, I2C_ACK);
    wr_ack("ip_ptr3", 8'h03, I2C_ACK);
    stop_c();
    start_c();
    wr_ack("ip_addr2", 8'h78, I2C_ACK);
    wr_ack("ip_bad", 8'h20, I2C_NACK);
    wr_ack("ip_idle", 8'h33, I2C_NACK);
    stop_c();
    start_c();
    wr_ack("ip_raddr", 8'h79, I2C_ACK);
    rd_q.push_back(8'h5A);
    rd_byte("ip_rd", I2C_NACK);
    stop_c();

    // one-cycle SDA glitch with SCL high
    m_sda = 1'b0;
    @(posedge clk);
    m_sda = 1'b1;
    wt(10);
    chk("gl_busy", 32'(busy), 0);
    m_scl = 1'b0; wt(Q);
    wr_ack("gl_addr", 8'h78, I2C_NACK);
    stop_c();

    // reset while target drives a read bit
    start_c();
    wr_ack("pr_addr", 8'h78, I2C_ACK);
    wr_ack("pr_ptr", 8'h02, I2C_ACK);
    stop_c();
    start_c();
    wr_ack("pr_raddr", 8'h79, I2C_ACK);
    bit_c(1'b1, r);
    chk("pr_b7", 32'(r), 1);
    bit_c(1'b1, r);
    chk("pr_b6", 32'(r), 0);
    bit_c(1'b1, r);
    chk("pr_b5", 32'(r), 1);
    @(negedge clk);
    chk("pr_drv", 32'(sda_oe), 1);
    @(posedge clk);
    PRESET = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pr_oe", 32'(sda_oe), 0);
    m_sda = 1'b1;
    m_scl = 1'b1;
    wt(5);
    PRESET = 1'b0;
    wt(10);
    chk("pr_busy", 32'(busy), 0);
    for (int i = 0; i < 16; i++)
      peek("pr_reg", 4'(i), 8'h00);
    wr_q.push_back({4'd5, 8'h77});
    start_c();
    wr_ack("pr_addr3", 8'h78, I2C_ACK);
    wr_ack("pr_ptr5", 8'h05, I2C_ACK);
    wr_ack("pr_d", 8'h77, I2C_ACK);
    stop_c();
    peek("pr_reg5", 4'd5, 8'h77);

    wt(4);
    chk("wr_left", 32'(wr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
